div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: TAG_W, default 5, width of destination-register tag carried with each op.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  1  op offered by issue stage.
REQ-005 Port: req_ready  output  1  block can accept an op this cycle.
REQ-006 Port: req_op  input  2  bit1=1 remainder / 0 quotient; bit0=1 unsigned / 0 signed (DIV=00, DIVU=01, REM=10, REMU=11).
REQ-007 Port: req_dividend  input  32  dividend operand.
REQ-008 Port: req_divisor  input  32  divisor operand.
REQ-009 Port: req_tag  input  TAG_W  destination tag.
REQ-010 Port: flush  input  1  pipeline kill; discards any in-flight op.
REQ-011 Port: core_start  output  1  one-cycle start pulse to the unsigned multi-cycle divider core.
REQ-012 Port: core_dividend  output  32  unsigned (magnitude) dividend to core, registered.
REQ-013 Port: core_divisor  output  32  unsigned (magnitude) divisor to core, registered.
REQ-014 Port: core_done  input  1  core result valid, single-cycle pulse.
REQ-015 Port: core_quotient  input  32  core unsigned quotient, valid with core_done.
REQ-016 Port: core_remainder  input  32  core unsigned remainder, valid with core_done.
REQ-017 Port: resp_valid  output  1  result available.
REQ-018 Port: resp_ready  input  1  writeback accepts result.
REQ-019 Port: resp_data  output  32  final RISC-V result.
REQ-020 Port: resp_tag  output  TAG_W  tag of resp_data.
REQ-021 Port: busy  output  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, START, WAIT, RESP, DRAIN; one op in flight at most.
REQ-023 req_ready = (state==IDLE) && !flush; accept = req_valid && req_ready; op, tag, operand signs and magnitudes captured on accept.
REQ-024 Special case divisor==0: IDLE->RESP, resp_data = 0xFFFFFFFF for quotient ops, dividend for remainder ops; core_start never asserted.
REQ-025 Special case signed overflow (op bit0=0, dividend 0x80000000, divisor 0xFFFFFFFF): IDLE->RESP, quotient 0x80000000, remainder 0; no core_start.
REQ-026 Special cases: resp_valid asserted the cycle after accept (latency 1).
REQ-027 Normal op: IDLE->START; core_start = (state==START) && !flush, exactly one cycle; START->WAIT.
REQ-028 Signed ops send two's-complement magnitudes to core; unsigned ops send operands unchanged.
REQ-029 WAIT: on core_done, register corrected result, go to RESP; latency accept->resp_valid = core latency + 2.
REQ-030 Sign correction: quotient negated iff signed op and operand signs differ; remainder negated iff signed op and dividend negative; result selected by op bit1.
REQ-031 RESP: resp_valid, resp_data, resp_tag held stable until resp_valid && resp_ready; then IDLE; no new accept in the handshake cycle.
REQ-032 core_done outside WAIT/DRAIN ignored.
REQ-033 Flush in START or RESP: next state IDLE, resp_valid low next cycle, no response for that op.
REQ-034 Flush in WAIT: next state DRAIN (or IDLE if core_done same cycle); DRAIN waits for core_done, discards result, then IDLE; req_ready low in DRAIN.
REQ-035 Flush in IDLE suppresses accept that cycle; flush in DRAIN has no further effect.

Reset
REQ-036 rst asynchronously forces IDLE; req_ready 1 once rst deasserts; resp_valid, core_start, busy 0; resp_data, resp_tag, core_dividend, core_divisor 0.
REQ-037 Reset mid-operation abandons the op; core_done arriving after reset release is ignored.

Verification
REQ-038 DIV 0xFFFFFFF9 (-7) / 2 -> core sees 7 and 2; resp_data 0xFFFFFFFD (-3), correct tag.
REQ-039 REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF (-1); REMU 0xFFFFFFF9 / 2 -> 1.
REQ-040 DIVU 5 / 0 -> resp_valid one cycle after accept, resp_data 0xFFFFFFFF, core_start never high; REM 5 / 0 -> 5.
REQ-041 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; no core_start.
REQ-042 Flush two cycles into WAIT, core_done 5 cycles later -> no resp_valid, req_ready low until cycle after core_done, next op completes correctly.
REQ-043 resp_ready held low 4 cycles in RESP -> resp_data/resp_tag stable, req_ready low, single transfer on release.

Source files
------------

// File: rtl/div_sched.sv
// rtl/div_sched.sv - RISC-V DIV/REM scheduler wrapping an unsigned multi-cycle divider core
module div_sched #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_dividend,
    input  logic [31:0]      req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             core_start,
    output logic [31:0]      core_dividend,
    output logic [31:0]      core_divisor,
    input  logic             core_done,
    input  logic [31:0]      core_quotient,
    input  logic [31:0]      core_remainder,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic        accept;
    logic        signed_op;
    logic        dvd_neg, dvs_neg;
    logic        is_zero, is_ovf, is_special;
    logic [31:0] dvd_mag, dvs_mag;
    logic [31:0] special_data;
    logic [31:0] q_fix, r_fix, core_result;
    logic        rem_q, q_neg_q, r_neg_q;

    assign req_ready  = (state == S_IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign core_start = (state == S_START) && !flush;
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    assign signed_op = ~req_op[0];
    assign dvd_neg   = signed_op & req_dividend[31];
    assign dvs_neg   = signed_op & req_divisor[31];
    assign dvd_mag   = dvd_neg ? -req_dividend : req_dividend;
    assign dvs_mag   = dvs_neg ? -req_divisor : req_divisor;

    // Divide-by-zero and INT_MIN/-1 have fixed architectural results and bypass the core.
    assign is_zero    = (req_divisor == 32'h0);
    assign is_ovf     = signed_op && (req_dividend == 32'h8000_0000) && (req_divisor == 32'hFFFF_FFFF);
    assign is_special = is_zero || is_ovf;
    assign special_data = is_zero ? (req_op[1] ? req_dividend : 32'hFFFF_FFFF)
                                  : (req_op[1] ? 32'h0 : 32'h8000_0000);

    assign q_fix       = q_neg_q ? -core_quotient : core_quotient;
    assign r_fix       = r_neg_q ? -core_remainder : core_remainder;
    assign core_result = rem_q ? r_fix : q_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_special ? S_RESP : S_START;
                end
            end
            S_START: begin
                state_nxt = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_nxt = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (core_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_dividend <= 32'h0;
            core_divisor  <= 32'h0;
            resp_data     <= 32'h0;
            resp_tag      <= '0;
            rem_q         <= 1'b0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
        end else begin
            if (accept) begin
                resp_tag <= req_tag;
                rem_q    <= req_op[1];
                q_neg_q  <= dvd_neg ^ dvs_neg;
                r_neg_q  <= dvd_neg;
                if (is_special) begin
                    resp_data <= special_data;
                end else begin
                    core_dividend <= dvd_mag;
                    core_divisor  <= dvs_mag;
                end
            end
            if ((state == S_WAIT) && core_done && !flush) begin
                resp_data <= core_result;
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - scoreboard bench for div_sched with behavioural divider core
module tb_div_sched;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_dividend;
    logic [31:0]      req_divisor;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             core_start;
    logic [31:0]      core_dividend;
    logic [31:0]      core_divisor;
    logic             core_done;
    logic [31:0]      core_quotient;
    logic [31:0]      core_remainder;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    div_sched #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
        .flush(flush),
        .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_core_exp = 0;
    int n_xfer = 0;
    int fixed_lat = 0;
    bit rand_rr = 1'b0;

    logic [TAG_W+31:0] scb[$];
    logic [63:0]       exp_core[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sd;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            sa = a;
            sd = b;
            return op[1] ? 32'(sa % sd) : 32'(sa / sd);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic logic [31:0] mag(input logic is_signed, input logic [31:0] x);
        int sx;
        sx = x;
        if (is_signed && sx < 0) return 32'(-sx);
        return x;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input bit expect_resp, input bit expect_core);
        bit acc;
        bit normal;
        acc = 1'b0;
        req_valid = 1'b1;
        req_op = op;
        req_dividend = a;
        req_divisor = b;
        req_tag = tag;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 64'(acc), 64'd1);
        end else begin
            normal = (b != 32'h0) && !(!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            if (expect_resp) scb.push_back({tag, ref_div(op, a, b)});
            if (normal && expect_core) begin
                exp_core.push_back({mag(!op[0], a), mag(!op[0], b)});
                n_core_exp++;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Behavioural unsigned divider core.
    initial begin
        logic [31:0] a, b;
        int lat;
        core_done = 1'b0;
        core_quotient = 32'h0;
        core_remainder = 32'h0;
        forever begin
            @(negedge clk);
            if (core_start && !rst) begin
                n_start++;
                a = core_dividend;
                b = core_divisor;
                if (exp_core.size() == 0) begin
                    chk("core_start_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_core.pop_front();
                    chk("core_dividend", 64'(a), 64'(e[63:32]));
                    chk("core_divisor", 64'(b), 64'(e[31:0]));
                end
                lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
                repeat (lat) @(posedge clk);
                #1;
                core_done = 1'b1;
                core_quotient = (b != 0) ? a / b : 32'hFFFF_FFFF;
                core_remainder = (b != 0) ? a % b : a;
                @(posedge clk);
                #1;
                core_done = 1'b0;
                core_quotient = $urandom;
                core_remainder = $urandom;
            end
        end
    end

    // Response monitor: pops the scoreboard on every handshake, checks hold stability.
    initial begin
        bit held_valid;
        logic [31:0] held_data;
        logic [TAG_W-1:0] held_tag;
        held_valid = 1'b0;
        held_data = 32'h0;
        held_tag = '0;
        forever begin
            @(negedge clk);
            if (rst || !resp_valid) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    chk("hold_data", 64'(resp_data), 64'(held_data));
                    chk("hold_tag", 64'(resp_tag), 64'(held_tag));
                end
                if (resp_ready) begin
                    held_valid = 1'b0;
                    if (scb.size() == 0) begin
                        chk("resp_unexpected", 64'(resp_data), 64'hDEAD_0000_0000);
                    end else begin
                        logic [TAG_W+31:0] e;
                        e = scb.pop_front();
                        chk("resp_data", 64'(resp_data), 64'(e[31:0]));
                        chk("resp_tag", 64'(resp_tag), 64'(e[TAG_W+31:32]));
                    end
                    n_xfer++;
                end else begin
                    held_valid = 1'b1;
                    held_data = resp_data;
                    held_tag = resp_tag;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rr) resp_ready = ($urandom % 3) != 0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int x0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_dividend = 32'h0;
        req_divisor = 32'h0;
        req_tag = '0;
        flush = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_tag", 64'(resp_tag), 64'd0);
        chk("rst_core_dividend", 64'(core_dividend), 64'd0);
        chk("rst_core_divisor", 64'(core_divisor), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // DIV -7/2 with known core latency 3: response after 3+2 cycles.
        fixed_lat = 3;
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, 1'b1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!resp_valid && c < 50);
        chk("norm_latency", 64'(c), 64'd5);
        wait_idle();
        fixed_lat = 0;

        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 1'b1);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 1'b1);
        wait_idle();

        // Special cases bypass the core and respond one cycle after accept.
        issue(2'b01, 32'd5, 32'd0, 5'd6, 1'b1, 1'b1);
        @(negedge clk);
        chk("div0_latency", 64'(resp_valid), 64'd1);
        issue(2'b10, 32'd5, 32'd0, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        chk("rem0_latency", 64'(resp_valid), 64'd1);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 1'b1);
        @(negedge clk);
        chk("ovf_latency", 64'(resp_valid), 64'd1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b1);
        wait_idle();
        chk("special_no_core_start", 64'(n_start), 64'(n_core_exp));

        // Flush two cycles into WAIT; core finishes 5 cycles after the flush.
        fixed_lat = 7;
        issue(2'b01, 32'd50, 32'd7, 5'd10, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("drain_req_ready", 64'(req_ready), 64'd0);
            chk("drain_resp_valid", 64'(resp_valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("post_drain_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        fixed_lat = 0;
        issue(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd11, 1'b1, 1'b1);
        wait_idle();

        // Backpressure: response held for 4 cycles then a single transfer.
        resp_ready = 1'b0;
        issue(2'b11, 32'h1234, 32'd0, 5'd12, 1'b1, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        x0 = n_xfer;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_single_xfer", 64'(n_xfer), 64'(x0 + 1));
        @(negedge clk);
        chk("bp_valid_drop", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;

        // Flush in RESP drops the response.
        resp_ready = 1'b0;
        issue(2'b01, 32'd5, 32'd0, 5'd13, 1'b0, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        chk("flush_resp_busy", 64'(busy), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Flush in START suppresses core_start.
        issue(2'b01, 32'd77, 32'd3, 5'd14, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_start_core_start", 64'(core_start), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Flush in IDLE blocks acceptance.
        req_valid = 1'b1;
        req_op = 2'b01;
        req_dividend = 32'd9;
        req_divisor = 32'd0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-operation; late core_done must be ignored.
        fixed_lat = 8;
        issue(2'b00, 32'd1000, 32'd3, 5'd15, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp_data", 64'(resp_data), 64'd0);
        chk("midrst_core_dividend", 64'(core_dividend), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_ignore_done", 64'(busy), 64'd0);
        fixed_lat = 0;

        // Randomized ops with random writeback backpressure.
        rand_rr = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom % 8)
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(1, 20)); end
                3: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = -32'($urandom_range(1, 20)); end
                default: ;
            endcase
            if (b == 32'h0 && ($urandom % 2 == 0)) b = 32'd1;
            issue(2'($urandom), a, b, 5'($urandom), 1'b1, 1'b1);
        end
        c = 0;
        while (scb.size() != 0 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        rand_rr = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);
        chk("core_start_count", 64'(n_start), 64'(n_core_exp));
        chk("core_queue_drained", 64'(exp_core.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
